// File: rtl/pe_cfg_loader_if.sv
// Config-packet types and the control/SRAM/mesh-ingress bundle of the PE config loader.
package pe_cfg_loader_pkg;
    localparam int unsigned PID_W   = 4;
    localparam int unsigned ENTRY_W = 16;

    typedef logic [PID_W-1:0]   pid_t;
    typedef logic [ENTRY_W-1:0] action_table_entry_t;

    typedef struct packed {
        logic [1:0]          x_coord;
        logic [1:0]          y_coord;
        pid_t                pat_ind;
        action_table_entry_t pat_w_entry;
    } conf_t;

    localparam int unsigned CFG_W = $bits(conf_t);

    typedef struct packed {
        conf_t conf;
    } payload_t;

    typedef struct packed {
        pid_t     pid;
        payload_t payload;
    } packet_t;
endpackage

interface pe_cfg_loader_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned CNT_W  = 8
);
    import pe_cfg_loader_pkg::*;

    logic              start_i;
    logic [ADDR_W-1:0] base_addr_i;
    logic [CNT_W-1:0]  count_i;
    logic              abort_i;
    logic              busy_o;
    logic              done_o;
    logic              mem_re_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [CFG_W-1:0]  mem_rdata_i;
    logic              out_full_i;
    logic              out_enq_o;
    packet_t           out_pkt_o;
    logic [CNT_W-1:0]  sent_cnt_o;

    modport master (
        output start_i, base_addr_i, count_i, abort_i, mem_rdata_i, out_full_i,
        input  busy_o, done_o, mem_re_o, mem_addr_o, out_enq_o, out_pkt_o, sent_cnt_o
    );

    modport slave (
        input  start_i, base_addr_i, count_i, abort_i, mem_rdata_i, out_full_i,
        output busy_o, done_o, mem_re_o, mem_addr_o, out_enq_o, out_pkt_o, sent_cnt_o
    );
endinterface

// File: rtl/pe_cfg_loader.sv
// Streams COUNT config words from a 1-cycle-latency SRAM into the mesh ingress FIFO as PID-0
// config packets, then waits a fixed drain window before pulsing done.
module pe_cfg_loader
    import pe_cfg_loader_pkg::*;
#(
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned DRAIN_CYCLES = 8
) (
    input  logic            clk,
    input  logic            rst,
    pe_cfg_loader_if.slave  bus
);
    localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [ADDR_W-1:0]  base_q, base_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   issued_q, issued_d;
    logic [CNT_W-1:0]   sent_q, sent_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic               done_q, done_d;
    logic               inflight_q, inflight_d;
    logic [1:0]         occ_q, occ_d;
    logic               wr_ptr_q, wr_ptr_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic [CFG_W-1:0]   buf_q [2];
    logic [CFG_W-1:0]   buf_d [2];

    logic               fetch_c;
    logic               enq_c;
    logic               re_c;
    logic [1:0]         occ_avail_c;

    // Read is allowed when the buffer, after this cycle's pop, plus the in-flight word leaves a free slot.
    always_comb begin
        fetch_c     = (state_q == S_FETCH);
        enq_c       = fetch_c && (occ_q != 2'd0) && !bus.out_full_i;
        occ_avail_c = occ_q - 2'(enq_c) + 2'(inflight_q);
        re_c        = fetch_c && (issued_q < count_q) && (occ_avail_c < 2'd2);
    end

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        count_d    = count_q;
        issued_d   = issued_q;
        sent_d     = sent_q;
        drain_d    = drain_q;
        done_d     = 1'b0;
        inflight_d = re_c;
        occ_d      = occ_q - 2'(enq_c) + 2'(inflight_q);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        buf_d      = buf_q;

        if (inflight_q) begin
            buf_d[wr_ptr_q] = bus.mem_rdata_i;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (enq_c) begin
            rd_ptr_d = ~rd_ptr_q;
            sent_d   = sent_q + CNT_W'(1);
        end
        if (re_c) begin
            issued_d = issued_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                // The done cycle is still IDLE, but a start there is deliberately ignored.
                if (bus.start_i && !bus.abort_i && !done_q) begin
                    base_d   = bus.base_addr_i;
                    count_d  = bus.count_i;
                    issued_d = '0;
                    sent_d   = '0;
                    if (bus.count_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                if (sent_d == count_q) begin
                    state_d = S_DRAIN;
                    drain_d = DRAIN_W'(DRAIN_CYCLES - 1);
                end
            end
            S_DRAIN: begin
                if (drain_q == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    drain_d = drain_q - DRAIN_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort flushes the buffer and forgets any read still in flight; sent count is kept.
        if (bus.abort_i) begin
            state_d    = S_IDLE;
            done_d     = 1'b0;
            inflight_d = 1'b0;
            occ_d      = 2'd0;
            wr_ptr_d   = 1'b0;
            rd_ptr_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            count_q    <= '0;
            issued_q   <= '0;
            sent_q     <= '0;
            drain_q    <= '0;
            done_q     <= 1'b0;
            inflight_q <= 1'b0;
            occ_q      <= 2'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            buf_q      <= '{default: '0};
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            count_q    <= count_d;
            issued_q   <= issued_d;
            sent_q     <= sent_d;
            drain_q    <= drain_d;
            done_q     <= done_d;
            inflight_q <= inflight_d;
            occ_q      <= occ_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            buf_q      <= buf_d;
        end
    end

    // Enqueue and read are combinational so they can honour same-cycle out_full.
    always_comb begin
        bus.busy_o     = (state_q != S_IDLE);
        bus.done_o     = done_q;
        bus.mem_re_o   = re_c;
        bus.mem_addr_o = re_c ? (base_q + ADDR_W'(issued_q)) : '0;
        bus.out_enq_o  = enq_c;
        bus.sent_cnt_o = sent_q;
        bus.out_pkt_o  = '0;
        if (enq_c) begin
            bus.out_pkt_o.payload.conf = conf_t'(buf_q[rd_ptr_q]);
        end
    end
endmodule

// File: tb/tb_pe_cfg_loader.sv
// Directed bench for pe_cfg_loader: SRAM model, ingress monitor, and per-scenario checks.
module tb_pe_cfg_loader;
    import pe_cfg_loader_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pe_cfg_loader_if #(.ADDR_W(8), .CNT_W(8)) bus ();

    pe_cfg_loader #(.ADDR_W(8), .CNT_W(8), .DRAIN_CYCLES(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [23:0] word_of(input logic [7:0] a);
        return {a, ~a, a ^ 8'h5A};
    endfunction

    function automatic packet_t exp_pkt(input logic [7:0] a);
        packet_t     p;
        logic [23:0] w;
        w = word_of(a);
        p = '0;
        p.payload.conf.x_coord     = w[23:22];
        p.payload.conf.y_coord     = w[21:20];
        p.payload.conf.pat_ind     = w[19:16];
        p.payload.conf.pat_w_entry = w[15:0];
        return p;
    endfunction

    // 1-cycle-latency config SRAM
    always @(posedge clk) begin
        if (bus.mem_re_o) bus.mem_rdata_i <= word_of(bus.mem_addr_o);
    end

    int         enq_cyc[$];
    packet_t    enq_pkt[$];
    int         re_cyc[$];
    logic [7:0] re_addr[$];
    int         done_cyc[$];
    int         busy_cnt;
    int         enq_full_viol;
    int         pkt_idle_viol;
    int         done_busy_viol;

    always @(negedge clk) begin
        if (bus.out_enq_o) begin
            enq_cyc.push_back(cyc);
            enq_pkt.push_back(bus.out_pkt_o);
            if (bus.out_full_i) enq_full_viol++;
        end else if (bus.out_pkt_o !== '0) begin
            pkt_idle_viol++;
        end
        if (bus.mem_re_o) begin
            re_cyc.push_back(cyc);
            re_addr.push_back(bus.mem_addr_o);
        end
        if (bus.done_o) begin
            done_cyc.push_back(cyc);
            if (bus.busy_o) done_busy_viol++;
        end
        if (bus.busy_o) busy_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic clear_logs();
        enq_cyc.delete(); enq_pkt.delete(); re_cyc.delete(); re_addr.delete(); done_cyc.delete();
        busy_cnt = 0; enq_full_viol = 0; pkt_idle_viol = 0; done_busy_viol = 0;
    endtask

    task automatic start_load(input logic [7:0] b, input logic [7:0] n, output int t);
        bus.base_addr_i = b;
        bus.count_i     = n;
        bus.start_i     = 1'b1;
        t = cyc;
        tick();
        bus.start_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start_i = 1'b0; bus.abort_i = 1'b0; bus.out_full_i = 1'b0;
        bus.base_addr_i = '0; bus.count_i = '0;
        repeat (3) tick();
        @(negedge clk);
        n_vec++; if (bus.busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", bus.busy_o); end
        n_vec++; if (bus.done_o !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", bus.done_o); end
        n_vec++; if (bus.mem_re_o !== 1'b0) begin n_err++; $display("FAIL reset_mem_re got %b want 0", bus.mem_re_o); end
        n_vec++; if (bus.out_enq_o !== 1'b0) begin n_err++; $display("FAIL reset_enq got %b want 0", bus.out_enq_o); end
        n_vec++; if (bus.out_pkt_o !== '0) begin n_err++; $display("FAIL reset_pkt got %h want 0", bus.out_pkt_o); end
        n_vec++; if (bus.sent_cnt_o !== 8'd0) begin n_err++; $display("FAIL reset_sent got %0d want 0", bus.sent_cnt_o); end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int t;
        logic [7:0] a;
        clear_logs();
        start_load(8'h10, 8'd3, t);
        run_to(t + 20);
        n_vec++; if (re_addr.size() != 3) begin n_err++; $display("FAIL basic_re_count got %0d want 3", re_addr.size()); end
        for (int i = 0; i < re_addr.size() && i < 3; i++) begin
            a = 8'(8'h10 + i);
            n_vec++;
            if (re_addr[i] !== a || re_cyc[i] != t + 1 + i) begin
                n_err++; $display("FAIL basic_re[%0d] got addr %h @%0d want %h @%0d", i, re_addr[i], re_cyc[i] - t, a, 1 + i);
            end
        end
        n_vec++; if (enq_pkt.size() != 3) begin n_err++; $display("FAIL basic_enq_count got %0d want 3", enq_pkt.size()); end
        for (int i = 0; i < enq_pkt.size() && i < 3; i++) begin
            a = 8'(8'h10 + i);
            n_vec++;
            if (enq_pkt[i] !== exp_pkt(a) || enq_cyc[i] != t + 3 + i) begin
                n_err++; $display("FAIL basic_enq[%0d] got %h @%0d want %h @%0d", i, enq_pkt[i], enq_cyc[i] - t, exp_pkt(a), 3 + i);
            end
        end
        n_vec++; if (done_cyc.size() != 1 || done_cyc[0] != t + 14) begin
            n_err++; $display("FAIL basic_done got %0d pulses first @%0d want 1 @14", done_cyc.size(), done_cyc.size() > 0 ? done_cyc[0] - t : -1);
        end
        n_vec++; if (bus.sent_cnt_o !== 8'd3) begin n_err++; $display("FAIL basic_sent got %0d want 3", bus.sent_cnt_o); end
        n_vec++; if (busy_cnt != 13 || done_busy_viol != 0) begin
            n_err++; $display("FAIL basic_busy got %0d cycles (%0d at done) want 13 (0)", busy_cnt, done_busy_viol);
        end
    endtask

    task automatic test_count_zero();
        int t;
        clear_logs();
        start_load(8'h10, 8'd0, t);
        run_to(t + 8);
        n_vec++; if (done_cyc.size() != 1 || done_cyc[0] != t + 1) begin
            n_err++; $display("FAIL zero_done got %0d pulses first @%0d want 1 @1", done_cyc.size(), done_cyc.size() > 0 ? done_cyc[0] - t : -1);
        end
        n_vec++; if (busy_cnt != 0 || re_cyc.size() != 0 || enq_cyc.size() != 0) begin
            n_err++; $display("FAIL zero_idle got busy %0d re %0d enq %0d want 0 0 0", busy_cnt, re_cyc.size(), enq_cyc.size());
        end
        n_vec++; if (bus.sent_cnt_o !== 8'd0) begin n_err++; $display("FAIL zero_sent got %0d want 0", bus.sent_cnt_o); end
    endtask

    task automatic test_backpressure();
        int t;
        int exp_enq[6] = '{3, 4, 9, 10, 11, 12};
        int exp_re[6]  = '{1, 2, 3, 4, 9, 10};
        logic [7:0] a;
        clear_logs();
        start_load(8'h40, 8'd6, t);
        run_to(t + 5);
        bus.out_full_i = 1'b1;
        run_to(t + 9);
        bus.out_full_i = 1'b0;
        run_to(t + 30);
        n_vec++; if (enq_full_viol != 0) begin n_err++; $display("FAIL bp_enq_while_full got %0d want 0", enq_full_viol); end
        n_vec++; if (re_cyc.size() != 6) begin n_err++; $display("FAIL bp_re_count got %0d want 6", re_cyc.size()); end
        for (int i = 0; i < re_cyc.size() && i < 6; i++) begin
            n_vec++;
            if (re_cyc[i] != t + exp_re[i]) begin n_err++; $display("FAIL bp_re[%0d] got @%0d want @%0d", i, re_cyc[i] - t, exp_re[i]); end
        end
        n_vec++; if (enq_pkt.size() != 6) begin n_err++; $display("FAIL bp_enq_count got %0d want 6", enq_pkt.size()); end
        for (int i = 0; i < enq_pkt.size() && i < 6; i++) begin
            a = 8'(8'h40 + i);
            n_vec++;
            if (enq_pkt[i] !== exp_pkt(a) || enq_cyc[i] != t + exp_enq[i]) begin
                n_err++; $display("FAIL bp_enq[%0d] got %h @%0d want %h @%0d", i, enq_pkt[i], enq_cyc[i] - t, exp_pkt(a), exp_enq[i]);
            end
        end
        n_vec++; if (done_cyc.size() != 1 || done_cyc[0] != t + 21) begin
            n_err++; $display("FAIL bp_done got %0d pulses first @%0d want 1 @21", done_cyc.size(), done_cyc.size() > 0 ? done_cyc[0] - t : -1);
        end
        n_vec++; if (pkt_idle_viol != 0) begin n_err++; $display("FAIL pkt_nonzero_idle got %0d want 0", pkt_idle_viol); end
    endtask

    task automatic test_abort();
        int t;
        int late;
        clear_logs();
        start_load(8'h80, 8'd5, t);
        run_to(t + 5);
        bus.abort_i = 1'b1;
        bus.out_full_i = 1'b1;
        tick();
        bus.abort_i = 1'b0;
        bus.out_full_i = 1'b0;
        @(negedge clk);
        n_vec++; if (bus.busy_o !== 1'b0) begin n_err++; $display("FAIL abort_busy got %b want 0", bus.busy_o); end
        run_to(t + 25);
        late = 0;
        foreach (re_cyc[i]) if (re_cyc[i] > t + 5) late++;
        foreach (enq_cyc[i]) if (enq_cyc[i] > t + 5) late++;
        n_vec++; if (late != 0) begin n_err++; $display("FAIL abort_late_activity got %0d want 0", late); end
        n_vec++; if (enq_pkt.size() != 2) begin n_err++; $display("FAIL abort_enq_count got %0d want 2", enq_pkt.size()); end
        n_vec++; if (done_cyc.size() != 0) begin n_err++; $display("FAIL abort_done got %0d want 0", done_cyc.size()); end
        n_vec++; if (bus.sent_cnt_o !== 8'd2) begin n_err++; $display("FAIL abort_sent got %0d want 2", bus.sent_cnt_o); end
        // abort and start together: start must be dropped
        clear_logs();
        bus.abort_i = 1'b1;
        start_load(8'h90, 8'd2, t);
        bus.abort_i = 1'b0;
        run_to(t + 15);
        n_vec++; if (busy_cnt != 0 || done_cyc.size() != 0 || re_cyc.size() != 0) begin
            n_err++; $display("FAIL abort_start got busy %0d done %0d re %0d want 0 0 0", busy_cnt, done_cyc.size(), re_cyc.size());
        end
        n_vec++; if (bus.sent_cnt_o !== 8'd2) begin n_err++; $display("FAIL abort_start_sent got %0d want 2", bus.sent_cnt_o); end
    endtask

    task automatic test_wrap_restart();
        int t;
        logic [7:0] exp_a[4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        clear_logs();
        start_load(8'hFE, 8'd4, t);
        run_to(t + 2);
        bus.base_addr_i = 8'h33; bus.count_i = 8'd9; bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        run_to(t + 15);
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        run_to(t + 35);
        n_vec++; if (re_addr.size() != 4) begin n_err++; $display("FAIL wrap_re_count got %0d want 4", re_addr.size()); end
        for (int i = 0; i < re_addr.size() && i < 4; i++) begin
            n_vec++;
            if (re_addr[i] !== exp_a[i]) begin n_err++; $display("FAIL wrap_addr[%0d] got %h want %h", i, re_addr[i], exp_a[i]); end
        end
        n_vec++; if (enq_pkt.size() != 4) begin n_err++; $display("FAIL wrap_enq_count got %0d want 4", enq_pkt.size()); end
        for (int i = 0; i < enq_pkt.size() && i < 4; i++) begin
            n_vec++;
            if (enq_pkt[i] !== exp_pkt(exp_a[i])) begin n_err++; $display("FAIL wrap_pkt[%0d] got %h want %h", i, enq_pkt[i], exp_pkt(exp_a[i])); end
        end
        n_vec++; if (done_cyc.size() != 1 || done_cyc[0] != t + 15) begin
            n_err++; $display("FAIL wrap_done got %0d pulses first @%0d want 1 @15", done_cyc.size(), done_cyc.size() > 0 ? done_cyc[0] - t : -1);
        end
        n_vec++; if (busy_cnt != 14) begin n_err++; $display("FAIL wrap_busy got %0d want 14", busy_cnt); end
        n_vec++; if (bus.sent_cnt_o !== 8'd4) begin n_err++; $display("FAIL wrap_sent got %0d want 4", bus.sent_cnt_o); end
    endtask

    task automatic test_max_count();
        int t;
        int bad;
        clear_logs();
        start_load(8'h00, 8'd255, t);
        run_to(t + 280);
        bad = 0;
        foreach (enq_pkt[i]) if (enq_pkt[i] !== exp_pkt(8'(i))) bad++;
        n_vec++; if (enq_pkt.size() != 255 || bad != 0) begin
            n_err++; $display("FAIL max_stream got %0d pkts %0d wrong want 255 0", enq_pkt.size(), bad);
        end
        n_vec++; if (bus.sent_cnt_o !== 8'd255) begin n_err++; $display("FAIL max_sent got %0d want 255", bus.sent_cnt_o); end
        n_vec++; if (done_cyc.size() != 1 || done_cyc[0] != t + 266) begin
            n_err++; $display("FAIL max_done got %0d pulses first @%0d want 1 @266", done_cyc.size(), done_cyc.size() > 0 ? done_cyc[0] - t : -1);
        end
    endtask

    task automatic test_reset_mid_fetch();
        int t;
        logic [7:0] a;
        clear_logs();
        bus.out_full_i = 1'b1;
        start_load(8'h20, 8'd6, t);
        run_to(t + 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.out_full_i = 1'b0;
        @(negedge clk);
        n_vec++;
        if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 || bus.mem_re_o !== 1'b0 || bus.out_enq_o !== 1'b0 ||
            bus.out_pkt_o !== '0 || bus.sent_cnt_o !== 8'd0) begin
            n_err++; $display("FAIL rstmid_outputs got busy %b done %b re %b enq %b pkt %h sent %0d want all 0",
                bus.busy_o, bus.done_o, bus.mem_re_o, bus.out_enq_o, bus.out_pkt_o, bus.sent_cnt_o);
        end
        tick();
        clear_logs();
        start_load(8'h20, 8'd3, t);
        run_to(t + 20);
        n_vec++; if (enq_pkt.size() != 3) begin n_err++; $display("FAIL rstmid_enq_count got %0d want 3", enq_pkt.size()); end
        for (int i = 0; i < enq_pkt.size() && i < 3; i++) begin
            a = 8'(8'h20 + i);
            n_vec++;
            if (enq_pkt[i] !== exp_pkt(a) || enq_cyc[i] != t + 3 + i) begin
                n_err++; $display("FAIL rstmid_enq[%0d] got %h @%0d want %h @%0d", i, enq_pkt[i], enq_cyc[i] - t, exp_pkt(a), 3 + i);
            end
        end
        n_vec++; if (done_cyc.size() != 1 || done_cyc[0] != t + 14) begin
            n_err++; $display("FAIL rstmid_done got %0d pulses first @%0d want 1 @14", done_cyc.size(), done_cyc.size() > 0 ? done_cyc[0] - t : -1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_count_zero();
        test_backpressure();
        test_abort();
        test_wrap_restart();
        test_max_count();
        test_reset_mid_fetch();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
